snn_conv_scheduler: RTL

Clocked sequencer for the SNN convolution datapath. After ifmap and filter memories are loaded, it walks every timestep and every output position. For each position it issues one window job to the PE cluster and collects the spike results in issue order. It then emits a per-timestep result header, ordered (addr, spike) result beats, and a final done token to the output/testbench interface.

---
 rtl/snn_conv_scheduler.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/snn_conv_scheduler.sv
// Timestep/position sequencer for the SNN convolution datapath: issues window jobs,
// reorders nothing (in-order PE), emits headers, result beats and a done token.
// Optional macro SNN_SCHED_PERF_EN adds perf_stall_cycles / perf_out_stall counters.
module snn_conv_scheduler #(
    parameter int IFMAP_DIM  = 25,
    parameter int FILTER_DIM = 5,
    parameter int OUT_DIM    = IFMAP_DIM - FILTER_DIM + 1,
    parameter int NUM_TS     = 2,
    parameter int ADDR_W     = 12,
    parameter int TS_W       = 2,
    parameter int MAX_OUT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_done,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [TS_W-1:0]   job_ts,
    output logic [ADDR_W-1:0] job_ifmap_base,
    output logic [ADDR_W-1:0] job_out_addr,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic              res_spike,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [TS_W-1:0]   hdr_ts,
    output logic [1:0]        hdr_layer,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_data,
    output logic              done_valid,
    input  logic              done_ready,
    output logic              busy
`ifdef SNN_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_out_stall
`endif
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int POS_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MAX_OUT - 1);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(OUT_DIM - 1);
    localparam logic [TS_W-1:0]   TS_LAST  = TS_W'(NUM_TS);
    // Moving from the last column of a row to column 0 of the next skips the filter overhang.
    localparam logic [ADDR_W-1:0] ROW_SKIP = ADDR_W'(IFMAP_DIM - OUT_DIM + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    logic [TS_W-1:0]   ts_r;
    logic [POS_W-1:0]  row_r;
    logic [POS_W-1:0]  col_r;
    logic [ADDR_W-1:0] ifmap_base_r;
    logic [ADDR_W-1:0] job_addr_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [ADDR_W-1:0] fifo_r [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic              out_valid_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              out_data_r;
    logic              hdr_valid_r;
    logic              job_valid_r;
    logic              done_valid_r;
    logic              busy_r;

    logic              job_fire_s;
    logic              res_fire_s;
    logic              out_fire_s;
    logic              res_ready_s;
    logic              last_pos_s;
    logic [CNT_W-1:0]  outstanding_nxt_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = ptr + PTR_W'(1);
        end
    endfunction

    // Handshake decode and next outstanding-job count.
    always_comb begin
        job_fire_s        = job_valid_r & job_ready;
        out_fire_s        = out_valid_r & out_ready;
        res_ready_s       = (state_r != ST_IDLE) && (outstanding_r != {CNT_W{1'b0}})
                            && (!out_valid_r || out_ready);
        res_fire_s        = res_ready_s & res_valid;
        last_pos_s        = (row_r == POS_LAST) && (col_r == POS_LAST);
        outstanding_nxt_s = outstanding_r;
        if (job_fire_s && !res_fire_s) begin
            outstanding_nxt_s = outstanding_r + CNT_W'(1);
        end else if (!job_fire_s && res_fire_s) begin
            outstanding_nxt_s = outstanding_r - CNT_W'(1);
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
    end

    // Sequencer FSM, in-order address FIFO and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ts_r          <= TS_W'(1);
            row_r         <= {POS_W{1'b0}};
            col_r         <= {POS_W{1'b0}};
            ifmap_base_r  <= {ADDR_W{1'b0}};
            job_addr_r    <= {ADDR_W{1'b0}};
            outstanding_r <= {CNT_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_addr_r    <= {ADDR_W{1'b0}};
            out_data_r    <= 1'b0;
            hdr_valid_r   <= 1'b0;
            job_valid_r   <= 1'b0;
            done_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (job_fire_s) begin
                fifo_r[wr_ptr_r] <= job_addr_r;
                wr_ptr_r         <= ptr_inc(wr_ptr_r);
            end
            if (res_fire_s) begin
                out_valid_r <= 1'b1;
                out_addr_r  <= fifo_r[rd_ptr_r];
                out_data_r  <= res_spike;
                rd_ptr_r    <= ptr_inc(rd_ptr_r);
            end else if (out_fire_s) begin
                out_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (load_done) begin
                        state_r      <= ST_HDR;
                        hdr_valid_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        ts_r         <= TS_W'(1);
                        row_r        <= {POS_W{1'b0}};
                        col_r        <= {POS_W{1'b0}};
                        ifmap_base_r <= {ADDR_W{1'b0}};
                        job_addr_r   <= {ADDR_W{1'b0}};
                    end
                end
                ST_HDR: begin
                    if (hdr_ready) begin
                        hdr_valid_r <= 1'b0;
                        job_valid_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (job_fire_s && last_pos_s) begin
                        job_valid_r <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        // Valid only ever drops here, and only right after the window fills.
                        job_valid_r <= (outstanding_nxt_s < MAX_CNT);
                        if (job_fire_s) begin
                            job_addr_r <= job_addr_r + ADDR_W'(1);
                            if (col_r == POS_LAST) begin
                                col_r        <= {POS_W{1'b0}};
                                row_r        <= row_r + POS_W'(1);
                                ifmap_base_r <= ifmap_base_r + ROW_SKIP;
                            end else begin
                                col_r        <= col_r + POS_W'(1);
                                ifmap_base_r <= ifmap_base_r + ADDR_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding_r == {CNT_W{1'b0}}) && !out_valid_r) begin
                        if (ts_r < TS_LAST) begin
                            ts_r         <= ts_r + TS_W'(1);
                            row_r        <= {POS_W{1'b0}};
                            col_r        <= {POS_W{1'b0}};
                            ifmap_base_r <= {ADDR_W{1'b0}};
                            job_addr_r   <= {ADDR_W{1'b0}};
                            hdr_valid_r  <= 1'b1;
                            state_r      <= ST_HDR;
                        end else begin
                            done_valid_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    hdr_valid_r  <= 1'b0;
                    job_valid_r  <= 1'b0;
                    done_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign job_valid      = job_valid_r;
    assign job_ts         = ts_r;
    assign job_ifmap_base = ifmap_base_r;
    assign job_out_addr   = job_addr_r;
    assign res_ready      = res_ready_s;
    assign hdr_valid      = hdr_valid_r;
    assign hdr_ts         = ts_r;
    assign hdr_layer      = 2'd1;
    assign out_valid      = out_valid_r;
    assign out_addr       = out_addr_r;
    assign out_data       = out_data_r;
    assign done_valid     = done_valid_r;
    assign busy           = busy_r;

`ifdef SNN_SCHED_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_out_stall_r;
    logic        stall_evt_s;
    logic        out_stall_evt_s;

    // Stall event decode.
    always_comb begin
        stall_evt_s     = (job_valid_r && !job_ready)
                          || ((state_r == ST_ISSUE) && (outstanding_r == MAX_CNT));
        out_stall_evt_s = out_valid_r && !out_ready;
    end

    // Saturating stall counters, cleared at the start of each run.
    always_ff @(posedge clk) begin
        if (reset || ((state_r == ST_IDLE) && load_done)) begin
            perf_stall_r     <= 32'd0;
            perf_out_stall_r <= 32'd0;
        end else begin
            if (stall_evt_s && (perf_stall_r != {32{1'b1}})) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
            if (out_stall_evt_s && (perf_out_stall_r != {32{1'b1}})) begin
                perf_out_stall_r <= perf_out_stall_r + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_out_stall    = perf_out_stall_r;
`endif

endmodule
